// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types for ram_arbiter_2p.
//   owner_t : which client a RAM access belongs to
//   state_t : arbiter FSM state (post-reset clear sweep, normal run)
//   tag_t   : return-pipe tag {valid, owner, is_read} following each granted access
package ram_arb_pkg;
   typedef enum logic {OWN_VID, OWN_CPU} owner_t;
   typedef enum logic {ST_CLEAR, ST_RUN} state_t;
   typedef struct packed {
      logic   valid;
      owner_t owner;
      logic   is_read;
   } tag_t;
endpackage

// File: rtl/ram_arb_if.sv
// ram_arb_if: client and RAM-side signals of the two-port RAM arbiter.
//   slave  : arbiter view (takes requests and ram_q, drives acks, read data, ram_*)
//   master : environment view (video/CPU clients and the RAM)
interface ram_arb_if #(
   parameter int ADDR_W = 11,
   parameter int DATA_W = 8
);
   logic              busy;
   logic              vid_req;
   logic [ADDR_W-1:0] vid_addr;
   logic              vid_ack;
   logic              vid_rvalid;
   logic [DATA_W-1:0] vid_rdata;
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_ack;
   logic              cpu_rvalid;
   logic [DATA_W-1:0] cpu_rdata;
   logic              ram_clken;
   logic              ram_wren;
   logic [ADDR_W-1:0] ram_address;
   logic [DATA_W-1:0] ram_data;
   logic [DATA_W-1:0] ram_q;

   modport slave (
      output busy,
      input  vid_req, vid_addr,
      output vid_ack, vid_rvalid, vid_rdata,
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_ack, cpu_rvalid, cpu_rdata,
      output ram_clken, ram_wren, ram_address, ram_data,
      input  ram_q
   );

   modport master (
      input  busy,
      output vid_req, vid_addr,
      input  vid_ack, vid_rvalid, vid_rdata,
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_ack, cpu_rvalid, cpu_rdata,
      input  ram_clken, ram_wren, ram_address, ram_data,
      output ram_q
   );
endinterface

// File: rtl/ram_arb_rd_pipe.sv
// ram_arb_rd_pipe: return path of the arbiter. Delays the grant tag two edges to line up
// with the RAM's registered q, then captures q into the owning client's rdata and pulses
// its rvalid.
//   clock, reset_n        : clock, asynchronous active-low reset
//   tag_in                : tag of the access granted this cycle
//   ram_q                 : RAM read data
//   vid_rvalid/vid_rdata  : video read return
//   cpu_rvalid/cpu_rdata  : CPU read return
module ram_arb_rd_pipe
   import ram_arb_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic              clock,
   input  logic              reset_n,
   input  tag_t              tag_in,
   input  logic [DATA_W-1:0] ram_q,
   output logic              vid_rvalid,
   output logic [DATA_W-1:0] vid_rdata,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata
);
   tag_t s1, s2;
   logic hit_vid, hit_cpu;

   // s2 describes the access the RAM performed at the previous edge, so ram_q belongs to it now
   always_comb begin
      hit_vid = s2.valid && s2.is_read && s2.owner == OWN_VID;
      hit_cpu = s2.valid && s2.is_read && s2.owner == OWN_CPU;
   end

   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         s1         <= '0;
         s2         <= '0;
         vid_rvalid <= 1'b0;
         cpu_rvalid <= 1'b0;
         vid_rdata  <= '0;
         cpu_rdata  <= '0;
      end else begin
         s1         <= tag_in;
         s2         <= s1;
         vid_rvalid <= hit_vid;
         cpu_rvalid <= hit_cpu;
         vid_rdata  <= hit_vid ? ram_q : vid_rdata;
         cpu_rdata  <= hit_cpu ? ram_q : cpu_rdata;
      end
endmodule

// File: rtl/ram_arbiter_2p.sv
// ram_arbiter_2p: shares one single-port 1-cycle-latency RAM between a priority video read
// port and a CPU read/write port. After reset it writes CLEAR_VAL to every address before
// granting any request.
//   clock, reset_n : clock, asynchronous active-low reset
//   bus (slave)    : busy, video port, CPU port and RAM-side signals
module ram_arbiter_2p
   import ram_arb_pkg::*;
#(
   parameter int                ADDR_W    = 11,
   parameter int                DATA_W    = 8,
   parameter int                MAX_WAIT  = 4,
   parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
   input logic      clock,
   input logic      reset_n,
   ram_arb_if.slave bus
);
   localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

   state_t            state, state_nx;
   logic [ADDR_W-1:0] clear_addr;
   logic [3:0]        wait_cnt, wait_nx;
   logic              clearing, vid_eff, cpu_eff, cpu_win, vid_win;
   tag_t              tag;

   // A client whose ack is showing is still holding the request it just got; masking it
   // stops the same request from being granted twice.
   always_comb begin
      clearing = state == ST_CLEAR;
      vid_eff  = bus.vid_req && !bus.vid_ack;
      cpu_eff  = bus.cpu_req && !bus.cpu_ack;
      cpu_win  = !clearing && cpu_eff && (!vid_eff || wait_cnt == WAIT_MAX);
      vid_win  = !clearing && vid_eff && !cpu_win;
      state_nx = clearing && &clear_addr ? ST_RUN : state;
      wait_nx  = clearing || !bus.cpu_req || cpu_win ? 4'd0 :
                 cpu_eff && wait_cnt != WAIT_MAX ? wait_cnt + 4'd1 : wait_cnt;
      tag.valid   = cpu_win || vid_win;
      tag.owner   = cpu_win ? OWN_CPU : OWN_VID;
      tag.is_read = vid_win || (cpu_win && !bus.cpu_we);
   end

   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) state <= ST_CLEAR;
      else state <= state_nx;

   // busy follows the state one edge late so it stays high until the RAM has done the last write
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         clear_addr      <= '0;
         wait_cnt        <= '0;
         bus.busy        <= 1'b0;
         bus.vid_ack     <= 1'b0;
         bus.cpu_ack     <= 1'b0;
         bus.ram_clken   <= 1'b0;
         bus.ram_wren    <= 1'b0;
         bus.ram_address <= '0;
         bus.ram_data    <= '0;
      end else begin
         clear_addr      <= clearing ? clear_addr + ADDR_W'(1) : clear_addr;
         wait_cnt        <= wait_nx;
         bus.busy        <= clearing;
         bus.vid_ack     <= vid_win;
         bus.cpu_ack     <= cpu_win;
         bus.ram_clken   <= clearing || cpu_win || vid_win;
         bus.ram_wren    <= clearing || (cpu_win && bus.cpu_we);
         bus.ram_address <= clearing ? clear_addr : cpu_win ? bus.cpu_addr : bus.vid_addr;
         bus.ram_data    <= clearing ? CLEAR_VAL : bus.cpu_wdata;
      end

   ram_arb_rd_pipe #(.DATA_W(DATA_W)) u_rd_pipe (
      .clock      (clock),
      .reset_n    (reset_n),
      .tag_in     (tag),
      .ram_q      (bus.ram_q),
      .vid_rvalid (bus.vid_rvalid),
      .vid_rdata  (bus.vid_rdata),
      .cpu_rvalid (bus.cpu_rvalid),
      .cpu_rdata  (bus.cpu_rdata)
   );
endmodule

// File: tb/tb_ram_arbiter_2p.sv
// tb_ram_arbiter_2p: scoreboard bench for ram_arbiter_2p with a behavioural RAM and reference model.
module tb_ram_arbiter_2p;
   localparam int            AW    = 4;
   localparam int            DW    = 8;
   localparam int            MW    = 4;
   localparam int            DEPTH = 1 << AW;
   localparam logic [DW-1:0] CV    = 8'hA5;

   typedef struct {
      int            due;
      bit            cpu;
      logic [DW-1:0] data;
   } rd_t;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;
   int   checks  = 0;
   int   errors  = 0;
   int   edge_n  = 0;
   int   bc, n;

   ram_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   ram_arbiter_2p #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW), .CLEAR_VAL(CV)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clock = ~clock;

   logic [DW-1:0] ram_mem [DEPTH];
   logic [DW-1:0] ram_q_r;
   assign bus.ram_q = ram_q_r;
   always @(posedge clock)
      if (bus.ram_clken) begin
         if (bus.ram_wren) ram_mem[bus.ram_address] <= bus.ram_data;
         else ram_q_r <= ram_mem[bus.ram_address];
      end

   bit            m_busy, m_vack, m_cack, m_clken, m_wren;
   int            m_clr, m_wait;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_data;
   logic [DW-1:0] mem_ref [DEPTH];
   rd_t           sb[$];

   task automatic chk(input bit ok, input string nm, input int act, input int exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, edge_n);
      end
   endtask

   function automatic void m_reset();
      m_busy = 0; m_vack = 0; m_cack = 0; m_clken = 0; m_wren = 0;
      m_clr = 0; m_wait = 0; m_addr = '0; m_data = '0;
      sb.delete();
      for (int i = 0; i < DEPTH; i++) mem_ref[i] = CV;
   endfunction

   // Reference: clear sweep of DEPTH writes, then one grant per edge by the priority rules.
   function automatic void m_step();
      bit v, c, cw, vw;
      if (m_clr < DEPTH) begin
         m_busy = 1; m_vack = 0; m_cack = 0; m_wait = 0;
         m_clken = 1; m_wren = 1; m_addr = AW'(m_clr); m_data = CV;
         m_clr++;
         return;
      end
      v  = bus.vid_req && !m_vack;
      c  = bus.cpu_req && !m_cack;
      cw = c && (!v || m_wait == MW);
      vw = v && !cw;
      if (!bus.cpu_req || cw) m_wait = 0;
      else if (c && m_wait < MW) m_wait++;
      m_busy = 0; m_vack = vw; m_cack = cw;
      m_clken = cw || vw; m_wren = cw && bus.cpu_we;
      if (cw) begin
         m_addr = bus.cpu_addr;
         if (bus.cpu_we) begin
            m_data = bus.cpu_wdata;
            mem_ref[bus.cpu_addr] = bus.cpu_wdata;
         end else sb.push_back('{due: edge_n + 2, cpu: 1'b1, data: mem_ref[bus.cpu_addr]});
      end else if (vw) begin
         m_addr = bus.vid_addr;
         sb.push_back('{due: edge_n + 2, cpu: 1'b0, data: mem_ref[bus.vid_addr]});
      end
   endfunction

   initial forever begin
      @(negedge reset_n);
      m_reset();
   end

   initial forever begin
      @(posedge clock);
      edge_n++;
      if (!reset_n) m_reset();
      else m_step();
   end

   initial forever begin
      bit            ev, ec;
      logic [DW-1:0] ed;
      @(negedge clock);
      if (!reset_n) begin
         chk({bus.busy, bus.vid_ack, bus.vid_rvalid, bus.cpu_ack, bus.cpu_rvalid, bus.ram_clken, bus.ram_wren} === 7'd0
             && bus.vid_rdata === '0 && bus.cpu_rdata === '0 && bus.ram_address === '0 && bus.ram_data === '0,
             "reset_outputs", int'({bus.busy, bus.vid_ack, bus.vid_rvalid, bus.cpu_ack, bus.cpu_rvalid, bus.ram_clken, bus.ram_wren}), 0);
      end else begin
         ev = 0; ec = 0; ed = '0;
         if (sb.size() > 0 && sb[0].due == edge_n) begin
            ec = sb[0].cpu;
            ev = !sb[0].cpu;
            ed = sb[0].data;
            void'(sb.pop_front());
         end
         chk(bus.busy === m_busy, "busy", int'(bus.busy), int'(m_busy));
         chk(bus.vid_ack === m_vack, "vid_ack", int'(bus.vid_ack), int'(m_vack));
         chk(bus.cpu_ack === m_cack, "cpu_ack", int'(bus.cpu_ack), int'(m_cack));
         chk({bus.ram_clken, bus.ram_wren} === {m_clken, m_wren}, "ram_ctl",
             int'({bus.ram_clken, bus.ram_wren}), int'({m_clken, m_wren}));
         if (m_clken) chk(bus.ram_address === m_addr, "ram_address", int'(bus.ram_address), int'(m_addr));
         if (m_wren) chk(bus.ram_data === m_data, "ram_data", int'(bus.ram_data), int'(m_data));
         chk(bus.vid_rvalid === ev, "vid_rvalid", int'(bus.vid_rvalid), int'(ev));
         chk(bus.cpu_rvalid === ec, "cpu_rvalid", int'(bus.cpu_rvalid), int'(ec));
         if (ev) chk(bus.vid_rdata === ed, "vid_rdata", int'(bus.vid_rdata), int'(ed));
         if (ec) chk(bus.cpu_rdata === ed, "cpu_rdata", int'(bus.cpu_rdata), int'(ed));
      end
   end

   task automatic vid_op(input logic [AW-1:0] a);
      int k = 0;
      bus.vid_req  = 1'b1;
      bus.vid_addr = a;
      do begin
         @(negedge clock);
         k++;
      end while (bus.vid_ack !== 1'b1 && k < 200);
      chk(bus.vid_ack === 1'b1, "vid_ack_wait", int'(bus.vid_ack), 1);
      bus.vid_req = 1'b0;
   endtask

   task automatic cpu_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      int k = 0;
      bus.cpu_req   = 1'b1;
      bus.cpu_we    = we;
      bus.cpu_addr  = a;
      bus.cpu_wdata = d;
      do begin
         @(negedge clock);
         k++;
      end while (bus.cpu_ack !== 1'b1 && k < 200);
      chk(bus.cpu_ack === 1'b1, "cpu_ack_wait", int'(bus.cpu_ack), 1);
      bus.cpu_req = 1'b0;
   endtask

   task automatic vid_stream(input int cnt, input int maxgap, input bit alt);
      for (int i = 0; i < cnt; i++) begin
         vid_op(alt ? ((i % 2) != 0 ? AW'(2) : AW'(1)) : AW'($urandom_range(DEPTH - 1)));
         repeat ($urandom_range(maxgap)) @(negedge clock);
      end
   endtask

   task automatic cpu_stream(input int cnt, input int maxgap, input bit fixed);
      for (int i = 0; i < cnt; i++) begin
         if (fixed) cpu_op(1'b0, AW'(5), DW'($urandom));
         else cpu_op(1'($urandom), AW'($urandom_range(DEPTH - 1)), DW'($urandom));
         repeat ($urandom_range(maxgap)) @(negedge clock);
      end
   endtask

   initial begin
      #300000;
      $display("FAIL global_timeout");
      $fatal(1);
   end

   initial begin
      bus.vid_req = 0; bus.vid_addr = '0;
      bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
      repeat (3) @(negedge clock);
      #2 reset_n = 1'b1;
      fork
         begin
            cpu_op(1'b0, AW'(3), 8'h00);
            repeat (2) @(negedge clock);
            chk(bus.cpu_rvalid === 1'b1 && bus.cpu_rdata === CV, "t1_read_latency",
                int'({bus.cpu_rvalid, bus.cpu_rdata}), int'({1'b1, CV}));
         end
         begin
            bc = 0;
            repeat (20) begin
               @(negedge clock);
               bc += int'(bus.busy);
            end
            chk(bc == 16, "t1_busy_cycles", bc, 16);
         end
      join
      cpu_op(1'b1, AW'(7), 8'h3C);
      cpu_op(1'b0, AW'(7), 8'h00);
      repeat (4) @(negedge clock);
      fork
         vid_stream(24, 0, 1'b0);
         cpu_stream(24, 0, 1'b0);
      join
      fork
         vid_stream(20, 0, 1'b1);
         cpu_stream(20, 0, 1'b1);
      join
      fork
         vid_stream(120, 3, 1'b0);
         cpu_stream(120, 3, 1'b0);
      join
      repeat (4) @(negedge clock);
      bus.vid_req = 1; bus.vid_addr = AW'(1);
      bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = AW'(5);
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (bus.cpu_ack !== 1'b1 && n < 20);
      chk(bus.cpu_ack === 1'b1, "t5_cpu_ack", int'(bus.cpu_ack), 1);
      bus.vid_req = 0; bus.cpu_req = 0;
      #2 reset_n = 1'b0;
      repeat (3) @(negedge clock);
      #2 reset_n = 1'b1;
      repeat (8) @(negedge clock);
      #2 reset_n = 1'b0;
      repeat (2) @(negedge clock);
      #2 reset_n = 1'b1;
      fork
         for (int a = 0; a < DEPTH; a++) vid_op(AW'(a));
         for (int a = DEPTH - 1; a >= 0; a--) cpu_op(1'b0, AW'(a), DW'($urandom));
      join
      repeat (5) @(negedge clock);
      chk(sb.size() == 0, "sb_drain", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
